// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, scheduler FSM states and default datapath width.
// Purely declarative; no latency or flow control of its own.
// Consumed by alu_core and alu_sched.
package alu_pkg;

    localparam int ALU_WIDTH = 6;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: logic, add/sub with carry/borrow, shifts, signed set-less-than.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when the result is sampled.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] shamt;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] dif;

    // Shift amounts past WIDTH-1 naturally fall out as 0 / sign-fill from the shift operators.
    assign shamt = b[SHW-1:0];
    assign sum   = {1'b0, a} + {1'b0, b};
    assign dif   = {1'b0, a} - {1'b0, b};

    always_comb begin
        out   = '0;
        carry = 1'b0;
        case (op)
            OP_AND: out = a & b;
            OP_OR:  out = a | b;
            OP_ADD: begin
                out   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            OP_SLL: out = a << shamt;
            OP_XOR: out = a ^ b;
            OP_SRL: out = a >> shamt;
            OP_SUB: begin
                out   = dif[WIDTH-1:0];
                carry = dif[WIDTH];
            end
            OP_SRA: out = $signed(a) >>> shamt;
            OP_SLT: out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: out = '0;
        endcase
    end

    assign zero = (out == '0);

endmodule

// File: rtl/alu_sched.sv
// Round-robin arbiter sharing one alu_core among NREQ requesters; ALU_SCHED_CHAIN_EN adds result chaining.
// Latency: grant in cycle t -> registered response visible in cycle t+2; one op per 3 cycles peak.
// Backpressure: response held until rsp_ready; no new grant until the response handshake completes.
module alu_sched
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int NREQ  = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [4*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    input  logic [NREQ-1:0]       req_chain,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_out,
    output logic                  rsp_carry,
    output logic                  rsp_zero
);

    typedef struct packed {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [IDW-1:0]   id;
    } cmd_t;

    state_t           state_q, state_d;
    cmd_t             cmd_q;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   cand;
    logic [IDW-1:0]   grant_idx;
    logic             grant_found;
    logic             accept;
    logic [WIDTH-1:0] grant_a;
    logic [WIDTH-1:0] alu_out;
    logic             alu_carry;
    logic             alu_zero;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(rr_ptr) + i) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // rst_n gates the grant so req_ready stays low while reset is held.
    assign accept = rst_n && ena && (state_q == IDLE) && grant_found;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant_idx] = 1'b1;
    end

`ifdef ALU_SCHED_CHAIN_EN
    logic [WIDTH-1:0] last_out;

    assign grant_a = req_chain[grant_idx] ? last_out : req_a[WIDTH*grant_idx +: WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       last_out <= '0;
        else if (ena && state_q == EXEC)  last_out <= alu_out;
    end
`else
    logic unused_chain;
    assign unused_chain = ^req_chain;
    assign grant_a      = req_a[WIDTH*grant_idx +: WIDTH];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ena) begin
            case (state_q)
                IDLE:    if (accept) state_d = EXEC;
                EXEC:    state_d = RESP;
                RESP:    if (rsp_valid && rsp_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q     <= '0;
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_out   <= '0;
            rsp_carry <= 1'b0;
            rsp_zero  <= 1'b0;
        end else if (ena) begin
            case (state_q)
                IDLE: if (accept) begin
                    cmd_q <= '{op: req_op[4*grant_idx +: 4], a: grant_a,
                               b: req_b[WIDTH*grant_idx +: WIDTH], id: grant_idx};
                end
                EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= cmd_q.id;
                    rsp_out   <= alu_out;
                    rsp_carry <= alu_carry;
                    rsp_zero  <= alu_zero;
                end
                RESP: if (rsp_valid && rsp_ready) begin
                    rsp_valid <= 1'b0;
                    rr_ptr    <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
                end
                default: ;
            endcase
        end
    end

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .op    (cmd_q.op),
        .a     (cmd_q.a),
        .b     (cmd_q.b),
        .out   (alu_out),
        .carry (alu_carry),
        .zero  (alu_zero)
    );

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a scoreboard of expected responses.
module tb_alu_sched;
    import alu_pkg::*;

    localparam int W = 6;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           ena;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [4*N-1:0] req_op;
    logic [W*N-1:0] req_a;
    logic [W*N-1:0] req_b;
    logic [N-1:0]   req_chain;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_out;
    logic           rsp_carry;
    logic           rsp_zero;

    typedef struct {
        int id;
        int out;
        int carry;
        int zero;
    } exp_t;

    exp_t exp_q[$];
    int   total    = 0;
    int   bad      = 0;
    int   cyc      = 0;
    int   last_exp = 0;

    int sw_op[9] = '{OP_SRA, OP_SLT, 15, OP_SLL, OP_SRL, OP_AND, OP_OR, OP_XOR, OP_SRA};
    int sw_a [9] = '{36,     63,     17, 5,      48,     12,     12,    21,     40};
    int sw_b [9] = '{2,      1,      9,  6,      7,      10,     3,     21,     7};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_chain (req_chain),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_out   (rsp_out),
        .rsp_carry (rsp_carry),
        .rsp_zero  (rsp_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(int id, int op, int a, int b);
        exp_t e;
        int sa, sb, sh, r;
        sa = (a >= 32) ? a - 64 : a;
        sb = (b >= 32) ? b - 64 : b;
        sh = b % 8;
        e.id    = id;
        e.carry = 0;
        r       = 0;
        case (op)
            0: r = a & b;
            1: r = a | b;
            2: begin r = a + b; e.carry = (r >= 64) ? 1 : 0; end
            3: r = (sh >= 6) ? 0 : (a << sh);
            4: r = a ^ b;
            5: r = (sh >= 6) ? 0 : (a >> sh);
            6: begin r = a - b; e.carry = (a < b) ? 1 : 0; end
            7: r = (sh >= 6) ? ((sa < 0) ? 63 : 0) : (sa >>> sh);
            8: r = (sa < sb) ? 1 : 0;
            default: r = 0;
        endcase
        e.out  = r & 63;
        e.zero = (e.out == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pop_chk();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("rsp_expected", exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_out", rsp_out, e.out);
            chk("rsp_carry", rsp_carry, e.carry);
            chk("rsp_zero", rsp_zero, e.zero);
        end
    endtask

    // Presents a request and returns the cycle in which it was accepted.
    task automatic do_req(input int id, input int op, input int a, input int b,
                          input bit chain, output int tacc);
        exp_t e;
        int   n;
        int   a_eff;
        req_op[4*id +: 4] = op[3:0];
        req_a[W*id +: W]  = a[W-1:0];
        req_b[W*id +: W]  = b[W-1:0];
        req_chain[id]     = chain;
        req_valid[id]     = 1'b1;
        #1;
        n = 0;
        while (req_ready[id] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("grant_wait", (n < 20) ? 1 : 0, 1);
        chk("grant_onehot", req_ready, 1 << id);
        a_eff = a;
`ifdef ALU_SCHED_CHAIN_EN
        if (chain) a_eff = last_exp;
`endif
        e        = model(id, op, a_eff, b);
        last_exp = e.out;
        exp_q.push_back(e);
        tacc = cyc;
        tick();
        req_valid[id] = 1'b0;
        req_chain[id] = 1'b0;
    endtask

    // Waits for the response, holds it off for 'hold' cycles, then consumes it.
    task automatic get_rsp(input int hold, output int tval);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("rsp_wait", (n < 20) ? 1 : 0, 1);
        tval = cyc;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", rsp_valid, 1);
            chk("hold_no_grant", req_ready, 0);
            if (exp_q.size() > 0) chk("hold_out", rsp_out, exp_q[0].out);
        end
        rsp_ready = 1'b1;
        pop_chk();
        tick();
        rsp_ready = 1'b0;
        chk("rsp_cleared", rsp_valid, 0);
    endtask

    initial begin
        int t0, t1, g, last_g, n;
        rst_n     = 1'b0;
        ena       = 1'b1;
        req_valid = '1;
        req_chain = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) tick();

        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_out", rsp_out, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_carry", rsp_carry, 0);
        chk("rst_rsp_zero", rsp_zero, 0);
        chk("rst_req_ready", req_ready, 0);
        req_valid = '0;
        rst_n     = 1'b1;
        tick();

        // Single request: ADD 40+30 -> 6 with carry, two cycles after the grant.
        do_req(2, OP_ADD, 40, 30, 1'b0, t0);
        get_rsp(0, t1);
        chk("single_latency", t1 - t0, 2);

        // Backpressure with a competing requester waiting behind it.
        do_req(1, OP_SUB, 5, 9, 1'b0, t0);
        req_op[3:0] = OP_AND;
        req_valid[0] = 1'b1;
        get_rsp(5, t1);
        do_req(0, OP_AND, 12, 10, 1'b0, t0);
        chk("bp_regrant_cycle", t0 - t1, 6);
        get_rsp(0, t1);

        for (int i = 0; i < 9; i++) begin
            do_req(i % 4, sw_op[i], sw_a[i], sw_b[i], 1'b0, t0);
            get_rsp(0, t1);
        end

        // ena low while an op is in EXEC: nothing advances.
        do_req(1, OP_ADD, 1, 2, 1'b0, t0);
        ena = 1'b0;
        repeat (3) begin
            tick();
            chk("ena_hold_exec", rsp_valid, 0);
        end
        ena = 1'b1;
        get_rsp(0, t1);

        ena       = 1'b0;
        req_valid = '1;
        repeat (3) begin
            #1;
            chk("ena_no_grant", req_ready, 0);
            tick();
        end
        req_valid = '0;
        ena       = 1'b1;
        tick();

        // Reset in EXEC discards the op and clears outputs without a clock edge.
        do_req(3, OP_ADD, 1, 1, 1'b0, t0);
        rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_rsp_out", rsp_out, 0);
        chk("arst_rsp_id", rsp_id, 0);
        chk("arst_req_ready", req_ready, 0);
        exp_q.delete();
        last_exp = 0;
        tick();
        rst_n = 1'b1;

        // Round-robin from a fresh reset: 0,1,2,3,0 with one grant every 3 cycles.
        for (int i = 0; i < N; i++) begin
            req_op[4*i +: 4] = OP_ADD;
            req_a[W*i +: W]  = W'(10 * i + 1);
            req_b[W*i +: W]  = W'(i + 2);
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        g      = 0;
        n      = 0;
        last_g = 0;
        #1;
        while ((g < 5 || exp_q.size() > 0) && n < 60) begin
            if (req_ready != '0) begin
                chk("rr_order", req_ready, 1 << (g % 4));
                if (g > 0) chk("rr_spacing", cyc - last_g, 3);
                last_g = cyc;
                exp_q.push_back(model(g % 4, OP_ADD, 10 * (g % 4) + 1, (g % 4) + 2));
                g++;
            end
            if (rsp_valid) pop_chk();
            tick();
            n++;
            if (g == 5) req_valid = '0;
        end
        chk("rr_grants", g, 5);
        rsp_ready = 1'b0;
        tick();

        // Chained ADD: second op uses the previous result as A when chaining is built in.
        do_req(0, OP_ADD, 3, 4, 1'b0, t0);
        get_rsp(0, t1);
        do_req(1, OP_ADD, 20, 1, 1'b1, t0);
        get_rsp(0, t1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
